op_arbiter: RTL and testbench
=============================

OP_ARBITER -- requirements
Module: op_arbiter

Interface
REQ-001 Parameter W, default 16: operand and result width in bits.
REQ-002 Parameter TMO, default 255: maximum cycles to wait for datapath pronto before a timeout; legal range 1..255.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset is asynchronous and active-low.
REQ-005 req0, req1  in  1  per-requester operation request, held high until the matching gnt.
REQ-006 x0, x1  in  W  per-requester operand, valid while the matching req is high.
REQ-007 gnt0, gnt1  out  1  one-cycle grant pulse; the operand was captured.
REQ-008 done0, done1  out  1  one-cycle completion pulse to the owning requester.
REQ-009 err  out  1  one-cycle pulse coincident with done when the operation timed out.
REQ-010 y  out  W  registered result of the last successful operation.
REQ-011 bc_start  out  1  one-cycle start pulse to the datapath control block.
REQ-012 bc_x  out  W  registered operand presented to the datapath.
REQ-013 bc_pronto  in  1  datapath completion flag.
REQ-014 bc_y  in  W  datapath result, valid while bc_pronto is high.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, START, WAIT and DONE.
REQ-016 IDLE: with any req high at a rising edge, the FSM SHALL select an owner, load bc_x from that owner's x and go to START; with no req it stays in IDLE.
REQ-017 Arbitration SHALL be round-robin: when both req are high, the requester not served last wins; a single req always wins.
REQ-018 START: the FSM SHALL assert bc_start and the owner's gnt for exactly this one cycle, clear the wait counter and go to WAIT.
REQ-019 bc_pronto SHALL be ignored in START.
REQ-020 WAIT, bc_pronto high: the FSM SHALL load y from bc_y and go to DONE with err_flag=0.
REQ-021 WAIT, bc_pronto low: the FSM SHALL increment the wait counter; when the counter equals TMO it SHALL go to DONE with err_flag=1 and leave y unchanged.
REQ-022 WAIT, bc_pronto high in the same cycle the counter reaches TMO: this SHALL be treated as success, with no err.
REQ-023 DONE: the FSM SHALL assert the owner's done and err=err_flag for exactly one cycle, record the owner as last-served and return to IDLE.
REQ-024 Latency: gnt is the cycle after req is sampled; done is no earlier than 3 cycles after req is sampled; every operation (successful or timed out) SHALL produce exactly one done pulse.
REQ-025 A req still high in DONE SHALL NOT be granted until IDLE re-arbitrates, so back-to-back operations take at least 4 cycles each.
REQ-026 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high in any cycle.
REQ-027 gnt, done, err and bc_start SHALL be low in every state other than those named above.
REQ-028 The wait counter SHALL be ceil(log2(TMO+1)) bits wide and SHALL NOT wrap.

Reset
REQ-029 rst low SHALL immediately force: state IDLE; gnt0, gnt1, done0, done1, err and bc_start low; y and bc_x all zero; last-served = requester 1, so requester 0 has first priority; wait counter zero.
REQ-030 Reset asserted mid-operation SHALL abandon that operation with no done pulse.
REQ-031 Reset release SHALL take effect on the next rising edge with the FSM in IDLE.

Structure
REQ-032 A shared package op_arb_pkg SHALL hold the state enumeration and the default values for W and TMO.
REQ-033 The wait counter SHALL be a sub-module tmo_counter with inputs clear and enable, and output hit (count == TMO).

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Single request: req0=1, x0=16'h0005, bc_pronto high 4 cycles after bc_start with bc_y=16'h007D -> gnt0 1 cycle after req, bc_x=0005, done0 pulse, y=007D, err=0.
- Simultaneous requests from reset: req0=req1=1 -> requester 0 served first, then requester 1; the next tie after that goes to requester 0.
- Timeout: TMO=8, bc_pronto held low -> done plus err exactly 9 cycles after bc_start, y unchanged.
- Boundary: bc_pronto rises on the cycle the counter reaches TMO -> err=0, y captured.
- Mid-operation reset: rst low during WAIT -> all outputs zero at once, no done pulse; a new req0 after release is served normally.
- Persistent requests: req0 and req1 held high for 20 cycles -> grants alternate 0,1,0,1…, never two consecutive grants to the same requester.

Source files
------------

// File: rtl/op_arb_pkg.sv
// Shared definitions for the two-requester operation arbiter:
// default parameter values, FSM state encoding and the timeout-counter width helper.
package op_arb_pkg;

    localparam int unsigned W_DEFAULT   = 16;
    localparam int unsigned TMO_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits needed to hold every count value from 0 up to and including tmo.
    function automatic int unsigned cnt_width(input int unsigned tmo);
        return $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/tmo_counter.sv
// Saturating wait counter for the arbiter: cleared while the datapath is started,
// advanced once per idle wait cycle, never wraps past TMO.
module tmo_counter
    import op_arb_pkg::*;
#(
    parameter int unsigned TMO = TMO_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int unsigned CW = cnt_width(TMO);

    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;

    assign count_inc = count + CW'(1);

    // hit flags the enabled step on which the count lands on TMO
    assign hit = (count_inc == CW'(TMO));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TMO))) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/op_arbiter.sv
// Round-robin arbiter sharing one datapath control block between two requesters,
// with a bounded wait for the datapath and a timeout error pulse.
module op_arbiter
    import op_arb_pkg::*;
#(
    parameter int unsigned W   = W_DEFAULT,
    parameter int unsigned TMO = TMO_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         err,
    output logic [W-1:0] y,
    output logic         bc_start,
    output logic [W-1:0] bc_x,
    input  logic         bc_pronto,
    input  logic [W-1:0] bc_y
);

    state_t state;
    logic   owner;
    logic   last;
    logic   pick_c;
    logic   cnt_clear;
    logic   cnt_enable;
    logic   cnt_hit;

    // On a tie the requester not served last wins; otherwise whoever asked.
    assign pick_c = (req0 && req1) ? ~last : ~req0;

    assign cnt_clear  = (state == START);
    assign cnt_enable = (state == WAIT) && !bc_pronto;

    tmo_counter #(
        .TMO (TMO)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .hit    (cnt_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            y        <= '0;
            bc_x     <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err      <= 1'b0;
            bc_start <= 1'b0;
        end else begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err      <= 1'b0;
            bc_start <= 1'b0;
            case (state)
                IDLE: begin
                    // Pulses set here are visible for exactly the START cycle
                    if (req0 || req1) begin
                        owner    <= pick_c;
                        bc_x     <= pick_c ? x1 : x0;
                        gnt0     <= ~pick_c;
                        gnt1     <= pick_c;
                        bc_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // Completion wins over a timeout landing on the same cycle
                    if (bc_pronto) begin
                        y     <= bc_y;
                        done0 <= ~owner;
                        done1 <= owner;
                        state <= DONE;
                    end else if (cnt_hit) begin
                        done0 <= ~owner;
                        done1 <= owner;
                        err   <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    last  <= owner;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_op_arbiter.sv
// Self-checking bench for op_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level timing model.
module tb_op_arbiter;

    localparam int unsigned W   = 16;
    localparam int unsigned TMO = 8;

    localparam int M_RAND = 0;
    localparam int M_HOLD = 1;
    localparam int M_ONCE = 2;
    localparam int M_OFF  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [W-1:0] x0 = '0;
    logic [W-1:0] x1 = '0;
    logic         gnt0, gnt1, done0, done1, err, bc_start;
    logic [W-1:0] y, bc_x;
    logic         bc_pronto = 1'b0;
    logic [W-1:0] bc_y = '0;

    op_arbiter #(
        .W   (W),
        .TMO (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .x0        (x0),
        .x1        (x1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .err       (err),
        .y         (y),
        .bc_start  (bc_start),
        .bc_x      (bc_x),
        .bc_pronto (bc_pronto),
        .bc_y      (bc_y)
    );

    always #5 clk = ~clk;

    // Transaction model: one operation at a time, described by its grant period,
    // completion period and outcome, all derived from the timing rules.
    int           n = 0;
    bit           busy = 1'b0;
    bit           own = 1'b0;
    bit           last = 1'b1;
    int           s = 0;
    int           dd = 0;
    int           dp = 0;
    bit           oerr = 1'b0;
    logic [W-1:0] op_y = '0;
    logic [W-1:0] m_y = '0;
    logic [W-1:0] m_bcx = '0;

    int           mode [2];
    bit           pend [2];
    logic [W-1:0] xv   [2];
    int           next_d = 0;
    bit           use_y = 1'b0;
    logic [W-1:0] next_y = '0;

    int n_chk = 0;
    int n_bad = 0;
    int gq[$];
    int obs_start = -1;
    int obs_gnt = -1;
    int obs_done = -1;
    bit obs_err = 1'b0;
    bit obs_own = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (period %0d)", tag, got, exp, n);
        end
    endtask

    // One clock period: drive inputs after the edge, check at the falling edge,
    // then advance the model to what the next rising edge decides.
    task automatic step();
        bit e_g;
        bit e_d;
        bit e_e;
        @(posedge clk);
        #1;
        n++;
        e_g = busy && (n == s);
        e_d = busy && (n == dp);
        e_e = e_d && oerr;
        if (e_d && !oerr) m_y = op_y;

        for (int i = 0; i < 2; i++) begin
            if (busy && (n == s + 1) && (int'(own) == i)) begin
                pend[i] = 1'b0;
                if (mode[i] == M_ONCE) mode[i] = M_OFF;
            end
            if (!pend[i]) begin
                case (mode[i])
                    M_HOLD: begin pend[i] = 1'b1; xv[i] = 16'($urandom); end
                    M_RAND: if ($urandom_range(0, 2) == 0) begin
                                pend[i] = 1'b1;
                                xv[i] = 16'($urandom);
                            end
                    M_ONCE: pend[i] = 1'b1;
                    default: ;
                endcase
            end
        end
        req0 = pend[0];
        req1 = pend[1];
        x0 = pend[0] ? xv[0] : 16'($urandom);
        x1 = pend[1] ? xv[1] : 16'($urandom);
        if (busy && (n > s) && (n < dp)) begin
            bc_pronto = (n == s + dd);
            bc_y = (n == s + dd) ? op_y : 16'($urandom);
        end else begin
            bc_pronto = ($urandom_range(0, 3) == 0);
            bc_y = 16'($urandom);
        end

        @(negedge clk);
        check("gnt0", gnt0, e_g && !own);
        check("gnt1", gnt1, e_g && own);
        check("bc_start", bc_start, e_g);
        check("done0", done0, e_d && !own);
        check("done1", done1, e_d && own);
        check("err", err, e_e);
        check("y", y, m_y);
        check("bc_x", bc_x, m_bcx);
        if (gnt0) gq.push_back(0);
        if (gnt1) gq.push_back(1);
        if (gnt0 || gnt1) obs_gnt = n;
        if (bc_start) obs_start = n;
        if (done0 || done1) begin
            obs_done = n;
            obs_err = err;
            obs_own = done1;
        end

        if (busy && (n == dp)) begin
            busy = 1'b0;
            last = own;
        end else if (!busy && (req0 || req1)) begin
            if (req0 && req1) own = !last;
            else own = req1;
            s = n + 1;
            dd = (next_d > 0) ? next_d : int'($urandom_range(1, 11));
            next_d = 0;
            oerr = (dd > int'(TMO));
            dp = s + (oerr ? int'(TMO) : dd) + 1;
            op_y = use_y ? next_y : 16'($urandom);
            use_y = 1'b0;
            m_bcx = own ? xv[1] : xv[0];
            busy = 1'b1;
        end
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) step();
    endtask

    // Asynchronous reset in the middle of a period; outputs must clear at once.
    task automatic do_reset();
        @(posedge clk);
        #1;
        n++;
        rst = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        bc_pronto = 1'b0;
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_done0", done0, 0);
        check("rst_done1", done1, 0);
        check("rst_err", err, 0);
        check("rst_start", bc_start, 0);
        check("rst_y", y, 0);
        check("rst_bc_x", bc_x, 0);
        busy = 1'b0;
        last = 1'b1;
        m_y = '0;
        m_bcx = '0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        mode[0] = M_OFF;
        mode[1] = M_OFF;
        next_d = 0;
        use_y = 1'b0;
        obs_done = -1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n++;
            check("rst_hold_done", done0 | done1, 0);
            check("rst_hold_gnt", gnt0 | gnt1, 0);
        end
        rst = 1'b1;
    endtask

    initial begin
        logic [W-1:0] y_hold;
        int           req_per;

        do_reset();

        // Single request
        mode[0] = M_ONCE;
        xv[0] = 16'h0005;
        next_d = 4;
        use_y = 1'b1;
        next_y = 16'h007D;
        req_per = n + 1;
        run(10);
        check("single_gnt_lat", obs_gnt - req_per, 1);
        check("single_bc_x", bc_x, 16'h0005);
        check("single_y", y, 16'h007D);
        check("single_err", obs_err, 0);
        check("single_owner", obs_own, 0);
        check("single_lat", obs_done - obs_start, 5);

        // Simultaneous requests from reset
        do_reset();
        gq.delete();
        mode[0] = M_ONCE;
        mode[1] = M_ONCE;
        run(30);
        mode[0] = M_ONCE;
        mode[1] = M_ONCE;
        run(30);
        check("tie_count", gq.size(), 4);
        if (gq.size() >= 3) begin
            check("tie_first", gq[0], 0);
            check("tie_second", gq[1], 1);
            check("tie_next", gq[2], 0);
        end

        // Timeout
        y_hold = m_y;
        mode[0] = M_ONCE;
        xv[0] = 16'h0A0A;
        next_d = 100;
        run(14);
        check("tmo_lat", obs_done - obs_start, 9);
        check("tmo_err", obs_err, 1);
        check("tmo_owner", obs_own, 0);
        check("tmo_y", y, y_hold);

        // Completion on the same cycle the count reaches TMO
        mode[1] = M_ONCE;
        xv[1] = 16'h0B0B;
        next_d = int'(TMO);
        use_y = 1'b1;
        next_y = 16'hBEEF;
        run(14);
        check("bnd_lat", obs_done - obs_start, 9);
        check("bnd_err", obs_err, 0);
        check("bnd_owner", obs_own, 1);
        check("bnd_y", y, 16'hBEEF);

        // Reset during WAIT
        mode[0] = M_ONCE;
        xv[0] = 16'h0C0C;
        next_d = 100;
        for (int k = 0; k < 20 && !(busy && (n >= s + 2)); k++) step();
        check("midrst_in_wait", busy && (n >= s + 2), 1);
        do_reset();
        check("midrst_no_done", obs_done, 32'hFFFF_FFFF);
        mode[0] = M_ONCE;
        xv[0] = 16'h1234;
        next_d = 2;
        use_y = 1'b1;
        next_y = 16'h4321;
        run(8);
        check("midrst_owner", obs_own, 0);
        check("midrst_bc_x", bc_x, 16'h1234);
        check("midrst_y", y, 16'h4321);
        check("midrst_lat", obs_done - obs_start, 3);

        // Persistent requests alternate
        gq.delete();
        mode[0] = M_HOLD;
        mode[1] = M_HOLD;
        run(40);
        mode[0] = M_OFF;
        mode[1] = M_OFF;
        run(30);
        check("alt_count", gq.size() >= 4, 1);
        for (int i = 1; i < gq.size(); i++) check("alt_order", gq[i], 1 - gq[i-1]);

        // Randomized traffic
        mode[0] = M_RAND;
        mode[1] = M_RAND;
        run(1500);
        mode[0] = M_OFF;
        mode[1] = M_OFF;
        run(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
